// File: rtl/line_compositor.sv
// Double-buffered line compositor: a chart generator draws one line into the draw
// bank while the display reads (and clears) the other bank, swapping on line_req.
module line_compositor #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_req,
    input  logic [15:0] bg_color,
    output logic        gen_start,
    output logic [11:0] gen_dy,
    input  logic        gen_done,
    input  logic [11:0] px_dx,
    input  logic [15:0] px_data,
    input  logic        px_wr,
    input  logic        rd_en,
    input  logic [9:0]  rd_x,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int          AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
    localparam logic [AW-1:0] LAST_X = AW'(H_ACTIVE - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DRAW, S_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          bank_sel_q, bank_sel_d;   // index of the draw bank
    logic [11:0]   line_cnt_q, line_cnt_d;
    logic          gen_start_q, gen_start_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          fs_pend_q, fs_pend_d;
    logic [15:0]   rd_data_q, rd_data_d;

    logic          px_ok, rd_hit;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_word [2];

    assign px_ok   = px_wr && (state_q == S_DRAW) && (px_dx < H_LIM);
    assign rd_hit  = rd_en && ({2'b00, rd_x} < H_LIM);
    assign rd_addr = AW'(rd_x);

    // Each bank has a single write port: INIT fill, otherwise pixel writes to the
    // draw bank or read-clears to the read bank, never both on one bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [15:0]   mem [H_ACTIVE];
        logic          we;
        logic [AW-1:0] waddr;
        logic [15:0]   wdata;

        always_comb begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            we    = 1'b0;
            waddr = '0;
            wdata = bg_color;
            if (state_q == S_INIT) begin
                we    = 1'b1;
                waddr = init_cnt_q;
            end else if (bank_sel_q == 1'(b)) begin
                we    = px_ok;
                waddr = AW'(px_dx);
                wdata = px_data;
            end else begin
                we    = rd_hit;
                waddr = rd_addr;
            end
        end

        // NOTE: storage arrays are deliberately not reset; INIT fills them instead.
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end

        assign rd_word[b] = mem[rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        bank_sel_d  = bank_sel_q;
        line_cnt_d  = line_cnt_q;
        fs_pend_d   = fs_pend_q;
        overrun_d   = overrun_q;
        gen_start_d = 1'b0;
        rd_data_d   = rd_data_q;

        if (overrun_clr) overrun_d = 1'b0;

        if (rd_hit)     rd_data_d = rd_word[~bank_sel_q];
        else if (rd_en) rd_data_d = bg_color;

        case (state_q)
            S_INIT: begin
                if (frame_start) fs_pend_d = 1'b1;
                if (init_cnt_q == LAST_X) begin
                    init_cnt_d = '0;
                    if (fs_pend_q || frame_start) begin
                        state_d     = S_DRAW;
                        line_cnt_d  = '0;
                        fs_pend_d   = 1'b0;
                        gen_start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (frame_start || fs_pend_q) begin
                    state_d     = S_DRAW;
                    line_cnt_d  = '0;
                    fs_pend_d   = 1'b0;
                    gen_start_d = 1'b1;
                end
            end
            S_DRAW: begin
                if (line_req) overrun_d = 1'b1;
                if (gen_done) begin
                    if (fs_pend_q || frame_start) begin
                        line_cnt_d  = '0;
                        fs_pend_d   = 1'b0;
                        gen_start_d = 1'b1;
                    end else begin
                        state_d = S_READY;
                    end
                end else if (frame_start) begin
                    fs_pend_d = 1'b1;
                end
            end
            S_READY: begin
                if (frame_start) begin
                    state_d     = S_DRAW;
                    line_cnt_d  = '0;
                    fs_pend_d   = 1'b0;
                    gen_start_d = 1'b1;
                end else if (line_req) begin
                    bank_sel_d = ~bank_sel_q;
                    line_cnt_d = line_cnt_q + 12'd1;
                    if (line_cnt_q + 12'd1 == V_LIM) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_DRAW;
                        gen_start_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d == S_INIT) || (state_d == S_DRAW);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            bank_sel_q  <= 1'b0;
            line_cnt_q  <= '0;
            gen_start_q <= 1'b0;
            busy_q      <= 1'b1;
            overrun_q   <= 1'b0;
            fs_pend_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            bank_sel_q  <= bank_sel_d;
            line_cnt_q  <= line_cnt_d;
            gen_start_q <= gen_start_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            fs_pend_q   <= fs_pend_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign gen_start = gen_start_q;
    assign gen_dy    = line_cnt_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign rd_data   = rd_data_q;

endmodule
